// File: rtl/au_project_select_driver_pkg.sv
// Shared types and sizing helpers for the project-select sequencer.
// The state encoding and timer width are shared by the top and its phase timer.
package au_project_select_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_LO,
    GAP,
    INC_HI,
    INC_LO,
    ENA_SETUP,
    ENA_HI,
    ENA_LO,
    DONE
  } sel_state_t;

  localparam int RST_CYCLES_DFLT   = 8;
  localparam int PULSE_CYCLES_DFLT = 4;

  // The timer is wide enough to hold the longer of the two phase lengths.
  function automatic int tmr_width(input int rst_cycles, input int pulse_cycles);
    int longest;
    longest = (rst_cycles > pulse_cycles) ? rst_cycles : pulse_cycles;
    return $clog2(longest) + 1;
  endfunction

  localparam int TMR_W_DFLT = tmr_width(RST_CYCLES_DFLT, PULSE_CYCLES_DFLT);

endpackage

// File: rtl/au_project_select_driver_if.sv
// Command and three-wire selector signals of the project-select driver.
// master is the driver's view; slave is the command/selector side.
interface au_project_select_driver_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] project_idx;
  logic             sel_rst_n;
  logic             sel_inc;
  logic             sel_ena;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, project_idx,
    output sel_rst_n, sel_inc, sel_ena, busy, done, err
  );

  modport slave (
    output start, project_idx,
    input  sel_rst_n, sel_inc, sel_ena, busy, done, err
  );
endinterface

// File: rtl/au_project_select_driver_phase_timer.sv
// Loadable down-counter that times every phase of the select sequence.
// Latency: value reflects a load on the following cycle; no backpressure.
// Holds at zero until reloaded.
module au_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign value = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/au_project_select_driver.sv
// Host-side sequencer: reset, idx increment pulses, then enable-latching pulse.
// Latency: busy one cycle after accepted start; starts while busy are dropped.
module au_project_select_driver
  import au_project_select_pkg::*;
#(
  parameter int IDX_W        = 8,
  parameter int MAX_PROJECT  = 17,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DFLT,
  parameter int RST_CYCLES   = RST_CYCLES_DFLT
) (
  input  logic                        clk,
  input  logic                        rst,
  au_project_select_driver_if.master  bus
);

  localparam int TMR_W   = tmr_width(RST_CYCLES, PULSE_CYCLES);
  localparam int LONGEST = (RST_CYCLES > PULSE_CYCLES) ? RST_CYCLES : PULSE_CYCLES;

  sel_state_t       state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] inc_cnt;
  logic [IDX_W-1:0] inc_cnt_nxt;
  logic             sel_rst_n_q, sel_inc_q, sel_ena_q, busy_q, done_q, err_q;

  logic             accept;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_zero;

  assign accept      = bus.start && (bus.project_idx <= IDX_W'(MAX_PROJECT));
  assign inc_cnt_nxt = inc_cnt + IDX_W'(1);

  // Every timed state is entered when the current phase expires, so the timer
  // reloads on expiry; only the IDLE exit loads the longer reset phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(PULSE_CYCLES - 1);
    if (state == IDLE) begin
      tmr_load = accept;
      tmr_val  = TMR_W'(RST_CYCLES - 1);
    end else if (state != DONE) begin
      tmr_load = tmr_zero;
    end
  end

  au_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx_q       <= '0;
      inc_cnt     <= '0;
      sel_rst_n_q <= 1'b1;
      sel_inc_q   <= 1'b0;
      sel_ena_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= RST_LO;
            idx_q       <= bus.project_idx;
            inc_cnt     <= '0;
            sel_rst_n_q <= 1'b0;
            sel_inc_q   <= 1'b0;
            sel_ena_q   <= 1'b0;
            busy_q      <= 1'b1;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end
        end
        RST_LO: if (tmr_zero) begin
          state       <= GAP;
          sel_rst_n_q <= 1'b1;
        end
        GAP: if (tmr_zero) begin
          if (idx_q == '0) begin
            state     <= ENA_SETUP;
            sel_ena_q <= 1'b1;
          end else begin
            state     <= INC_HI;
            sel_inc_q <= 1'b1;
          end
        end
        INC_HI: if (tmr_zero) begin
          state     <= INC_LO;
          sel_inc_q <= 1'b0;
        end
        INC_LO: if (tmr_zero) begin
          inc_cnt <= inc_cnt_nxt;
          if (inc_cnt_nxt == idx_q) begin
            state     <= ENA_SETUP;
            sel_ena_q <= 1'b1;
          end else begin
            state     <= INC_HI;
            sel_inc_q <= 1'b1;
          end
        end
        ENA_SETUP: if (tmr_zero) begin
          state     <= ENA_HI;
          sel_inc_q <= 1'b1;
        end
        ENA_HI: if (tmr_zero) begin
          state     <= ENA_LO;
          sel_inc_q <= 1'b0;
        end
        ENA_LO: if (tmr_zero) begin
          state  <= DONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel_rst_n = sel_rst_n_q;
  assign bus.sel_inc   = sel_inc_q;
  assign bus.sel_ena   = sel_ena_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  a_done_err_excl: assert property (@(posedge clk) disable iff (rst) !(done_q && err_q));
  a_tmr_bound:     assert property (@(posedge clk) disable iff (rst)
                                    tmr_value <= TMR_W'(LONGEST - 1));

endmodule

// File: tb/tb_au_project_select_driver.sv
// Directed bench for au_project_select_driver with a downstream selector model.
// Checks waveform shape, busy length, err/done pulses, reset abort and idx sweep.
module tb_au_project_select_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  au_project_select_driver_if #(.IDX_W(8)) sif ();

  au_project_select_driver #(
    .IDX_W        (8),
    .MAX_PROJECT  (17),
    .PULSE_CYCLES (4),
    .RST_CYCLES   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  // Monitor and downstream selector model, sampled on the falling edge.
  int   cyc = 0, edges = 0, edges_ena = 0, rst_lo_cyc = 0, busy_cyc = 0;
  int   done_cnt = 0, err_cnt = 0, ena_rise_cyc = 0, ena_lead = 0, m_cnt = 0;
  bit   m_ena = 1'b0;
  logic prev_inc = 1'b0, prev_ena = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (sif.sel_rst_n === 1'b0) rst_lo_cyc++;
    if (sif.busy === 1'b1) busy_cyc++;
    if (sif.done === 1'b1) done_cnt++;
    if (sif.err === 1'b1) err_cnt++;
    if (sif.sel_ena === 1'b1 && prev_ena !== 1'b1) ena_rise_cyc = cyc;
    if (sif.sel_rst_n === 1'b0) begin
      m_cnt = 0;
      m_ena = 1'b0;
    end else if (sif.sel_inc === 1'b1 && prev_inc !== 1'b1) begin
      edges++;
      if (sif.sel_ena === 1'b1) begin
        edges_ena++;
        ena_lead = cyc - ena_rise_cyc;
        m_ena    = 1'b1;
      end else if (!m_ena) begin
        m_cnt++;
      end
    end
    prev_inc = sif.sel_inc;
    prev_ena = sif.sel_ena;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int d_edges, d_edges_ena, d_rst_lo, d_busy, d_done;

  task automatic run_seq(input int idx, input int restart_at);
    int  s_edges, s_edges_ena, s_rst_lo, s_busy, s_done;
    bit  seen;
    s_edges = edges; s_edges_ena = edges_ena; s_rst_lo = rst_lo_cyc;
    s_busy = busy_cyc; s_done = done_cnt;
    @(negedge clk);
    sif.start       = 1'b1;
    sif.project_idx = idx[7:0];
    @(negedge clk);
    sif.start = 1'b0;
    chk("busy_rise", sif.busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (sif.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (i == restart_at) begin
          sif.start       = 1'b1;
          sif.project_idx = 8'd7;
        end else begin
          sif.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    sif.start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    else       chk("busy_at_done", sif.busy, 0);
    repeat (3) @(negedge clk);
    d_edges     = edges - s_edges;
    d_edges_ena = edges_ena - s_edges_ena;
    d_rst_lo    = rst_lo_cyc - s_rst_lo;
    d_busy      = busy_cyc - s_busy;
    d_done      = done_cnt - s_done;
  endtask

  int s_done_e, s_err_e;

  initial begin
    sif.start       = 1'b0;
    sif.project_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel_rst_n", sif.sel_rst_n, 1);
    chk("rst_sel_inc",   sif.sel_inc,   0);
    chk("rst_sel_ena",   sif.sel_ena,   0);
    chk("rst_busy",      sif.busy,      0);
    chk("rst_done",      sif.done,      0);
    chk("rst_err",       sif.err,       0);
    rst = 1'b0;

    // idx=3 with a start repeated during the second INC_HI phase
    run_seq(3, 20);
    chk("i3_rst_lo",   d_rst_lo,    8);
    chk("i3_edges",    d_edges,     4);
    chk("i3_ena_edge", d_edges_ena, 1);
    chk("i3_ena_lead", ena_lead,    4);
    chk("i3_busy",     d_busy,      48);
    chk("i3_done",     d_done,      1);
    chk("i3_ena_hold", sif.sel_ena, 1);
    chk("i3_m_cnt",    m_cnt,       3);
    chk("i3_m_ena",    m_ena,       1);

    // out-of-range request
    s_done_e = done_cnt; s_err_e = err_cnt;
    sif.start = 1'b1; sif.project_idx = 8'd18;
    @(negedge clk);
    sif.start = 1'b0;
    chk("e_err",       sif.err,       1);
    chk("e_busy",      sif.busy,      0);
    chk("e_sel_inc",   sif.sel_inc,   0);
    chk("e_sel_rst_n", sif.sel_rst_n, 1);
    chk("e_sel_ena",   sif.sel_ena,   1);
    repeat (3) @(negedge clk);
    chk("e_err_pulse", err_cnt - s_err_e, 1);
    chk("e_no_done",   done_cnt - s_done_e, 0);

    // idx=0
    run_seq(0, -1);
    chk("i0_edges",    d_edges,     1);
    chk("i0_ena_edge", d_edges_ena, 1);
    chk("i0_busy",     d_busy,      24);
    chk("i0_done",     d_done,      1);

    // reset abort during INC_LO, then a fresh idx=5 run
    sif.start = 1'b1; sif.project_idx = 8'd3;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (17) @(negedge clk);
    chk("ab_busy_pre", sif.busy,    1);
    chk("ab_inc_lo",   sif.sel_inc, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_sel_rst_n", sif.sel_rst_n, 1);
    chk("ab_sel_inc",   sif.sel_inc,   0);
    chk("ab_sel_ena",   sif.sel_ena,   0);
    chk("ab_busy",      sif.busy,      0);
    chk("ab_done",      sif.done,      0);
    chk("ab_err",       sif.err,       0);
    run_seq(5, -1);
    chk("i5_edges", d_edges, 6);
    chk("i5_busy",  d_busy,  64);
    chk("i5_m_cnt", m_cnt,   5);
    chk("i5_m_ena", m_ena,   1);

    // back-to-back sweep of every legal index against the selector model
    for (int k = 0; k <= 17; k++) begin
      run_seq(k, -1);
      chk($sformatf("sw%0d_cnt", k),   m_cnt,   k);
      chk($sformatf("sw%0d_ena", k),   m_ena,   1);
      chk($sformatf("sw%0d_busy", k),  d_busy,  8 + 4 * (2 * k + 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/au_project_select_driver.md
Name: au_project_select_driver

Overview:
Host-side sequencer that generates the three-wire project-select protocol (sel_rst_n, sel_inc, sel_ena) consumed by the on-chip project-selector counter.
On a start request it performs three steps:
- resets the downstream counter;
- issues project_idx increment pulses with sel_ena low;
- raises sel_ena and issues one final increment, which latches the downstream enable.
It sits in the FPGA top level between the command/control logic and the emulated project mux.

Parameters:
IDX_W, 8, width of project_idx
MAX_PROJECT, 17, highest legal project index (matches receiver PROJECT_NUMBER)
PULSE_CYCLES, 4, clk cycles per high phase and per low phase of sel_inc; also ena setup and post-reset gap; must be >=1
RST_CYCLES, 8, clk cycles sel_rst_n held low; must be >=1

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to select project_idx
project_idx  input  IDX_W  target project number, sampled when start accepted
sel_rst_n  output  1  downstream selector reset, active-low
sel_inc  output  1  downstream increment strobe, rising edge significant
sel_ena  output  1  downstream enable qualifier
busy  output  1  sequence in progress
done  output  1  one-cycle pulse, sequence complete
err  output  1  one-cycle pulse, start rejected (idx > MAX_PROJECT)

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: sel_rst_n=1, sel_inc=0, sel_ena=0, busy=0, done=0, err=0, state=IDLE.
- rst asserted mid-sequence aborts on the next edge to the reset values; the downstream counter may be left partially advanced. That is acceptable because every new sequence re-resets it.

States:
- IDLE:
  - start=1 and project_idx<=MAX_PROJECT: latch idx, clear pulse count, go to RST_LO. busy=1 from the next cycle.
  - start=1 and idx>MAX_PROJECT: err=1 next cycle, stay IDLE, outputs otherwise unchanged.
- RST_LO: sel_rst_n=0, sel_ena=0, sel_inc=0 for RST_CYCLES cycles, then go to GAP.
- GAP: sel_rst_n=1 for PULSE_CYCLES cycles.
  - If idx==0, go to ENA_SETUP.
  - Otherwise go to INC_HI.
- INC_HI: sel_inc=1 for PULSE_CYCLES cycles, then go to INC_LO.
- INC_LO: sel_inc=0 for PULSE_CYCLES cycles. The pulse count increments on exit.
  - If count==idx, go to ENA_SETUP.
  - Otherwise go to INC_HI.
- ENA_SETUP: sel_ena=1, sel_inc=0 for PULSE_CYCLES cycles. This guarantees sel_ena is stable before the final edge.
- ENA_HI: sel_inc=1, sel_ena=1 for PULSE_CYCLES cycles.
- ENA_LO: sel_inc=0, sel_ena=1 for PULSE_CYCLES cycles, then go to DONE.
- DONE: done=1, busy=0 for one cycle, then go to IDLE.

Post-sequence levels:
- sel_ena remains 1 in IDLE after a completed sequence, keeping the selection stable.
- sel_ena is cleared on entry to RST_LO of the next sequence, or by rst.

Timing:
- start is ignored while busy=1; no queueing.
- The phase timer is a down-counter loaded with N-1 on state entry. The state exits when the counter reads 0.
- Total busy cycles = RST_CYCLES + PULSE_CYCLES*(2*idx + 4).
- Latency: busy rises exactly one cycle after accepted start. done appears the cycle after the last busy cycle.
- The internal pulse counter is IDX_W bits wide. It cannot wrap because idx<=MAX_PROJECT<2^IDX_W is checked at start.
- At most one of done and err is high in any cycle.

Decomposition:
- Shared package au_project_select_pkg:
  - state enum (IDLE, RST_LO, GAP, INC_HI, INC_LO, ENA_SETUP, ENA_HI, ENA_LO, DONE);
  - localparam timer width $clog2(max(RST_CYCLES,PULSE_CYCLES))+1.
- One sub-module, au_phase_timer: loadable down-counter with load, value, and zero flag, shared by all timed states.
- The FSM and pulse counter stay in the top module.

Test Plan:
- rst, then start with project_idx=3, PULSE_CYCLES=4, RST_CYCLES=8:
  - sel_rst_n is low 8 cycles, followed by exactly 4 sel_inc rising edges;
  - sel_ena rises 4 cycles before the 4th edge, and is low at the first 3 edges;
  - busy is high for 48 cycles, then done is a single pulse;
  - sel_ena stays 1 afterward.
- project_idx=0: no sel_inc edges before ENA_SETUP; exactly one edge with sel_ena=1; busy is high for 24 cycles.
- project_idx=18 (MAX_PROJECT=17): err pulses 1 cycle; busy, sel_inc and sel_rst_n are unchanged; no done.
- start asserted again during INC_HI, at cycle 20 of the idx=3 run: ignored; edge count is still 4; done fires once.
- rst asserted during INC_LO: next cycle, all outputs take reset values and state is IDLE. A fresh start with idx=5 then completes with 6 edges.
- Scoreboard against a behavioural model of the downstream selector (MAX_PROJECT=17), for idx 0..17 back-to-back: the model's ena=1 and counter==idx after each done.
